// File: rtl/aes_ahb_master_if.sv
// AHB-Lite bus bundle between the AES SRAM master and its slave.
// Only the signals used by a non-pipelined single-word master are carried.
interface aes_ahb_master_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/aes_ahb_master.sv
// AHB-Lite master moving one AES block (NUM_WORDS words) per controller request,
// with source/destination pointers, block counters and a last_round hint.
module aes_ahb_master #(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_load,
    input  logic [31:0]             cfg_src_addr,
    input  logic [31:0]             cfg_dst_addr,
    input  logic [CNT_W-1:0]        cfg_num_blocks,
    input  logic                    ahb_mode,
    input  logic                    ahb_shift_en,
    input  logic [32*NUM_WORDS-1:0] tx_block,
    output logic [32*NUM_WORDS-1:0] rx_block,
    output logic                    rx_valid,
    output logic                    xfer_done,
    output logic                    last_round,
    output logic                    busy,
    output logic                    err,
    aes_ahb_master_if.master        ahb
);

    localparam int unsigned BlkW     = 32 * NUM_WORDS;
    localparam int unsigned IdxW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_WORDS - 1);
    localparam logic [31:0]     BlkBytes = 32'(4 * NUM_WORDS);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [BlkW-1:0]   buf_q, buf_d;
    logic [BlkW-1:0]   rx_block_q, rx_block_d;
    logic [IdxW-1:0]   word_idx_q, word_idx_d;
    logic [31:0]       src_ptr_q, src_ptr_d;
    logic [31:0]       dst_ptr_q, dst_ptr_d;
    logic [CNT_W-1:0]  nblk_q, nblk_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              err_q, err_d;
    logic [31:0]       base_addr;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        buf_d      = buf_q;
        rx_block_d = rx_block_q;
        word_idx_d = word_idx_q;
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        nblk_d     = nblk_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;

        ahb.htrans = 2'b00;
        ahb.hwrite = 1'b0;
        ahb.haddr  = 32'h0;
        ahb.hwdata = 32'h0;
        ahb.hsize  = 3'b010;

        base_addr = mode_q ? dst_ptr_q : src_ptr_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_load) begin
                    src_ptr_d = cfg_src_addr;
                    dst_ptr_d = cfg_dst_addr;
                    nblk_d    = (cfg_num_blocks == '0) ? CNT_W'(1) : cfg_num_blocks;
                    rd_cnt_d  = '0;
                    wr_cnt_d  = '0;
                    err_d     = 1'b0;
                end
                if (ahb_shift_en) begin
                    mode_d     = ahb_mode;
                    word_idx_d = '0;
                    state_d    = StAddr;
                    if (ahb_mode) begin
                        buf_d = tx_block;
                    end
                end
            end
            StAddr: begin
                ahb.htrans = 2'b10;
                ahb.hwrite = mode_q;
                ahb.haddr  = base_addr + 32'({word_idx_q, 2'b00});
                if (ahb.hready) begin
                    state_d = StData;
                end
            end
            StData: begin
                // The write buffer shifts left per word, so its top word is always current.
                if (mode_q) begin
                    ahb.hwdata = buf_q[BlkW-1 -: 32];
                end
                if (ahb.hready) begin
                    if (ahb.hresp) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        if (mode_q) begin
                            buf_d = {buf_q[BlkW-33:0], 32'h0};
                        end else begin
                            rx_block_d = {rx_block_q[BlkW-33:0], ahb.hrdata};
                        end
                        if (word_idx_q == LastIdx) begin
                            state_d = StDone;
                        end else begin
                            word_idx_d = word_idx_q + IdxW'(1);
                            state_d    = StAddr;
                        end
                    end
                end
            end
            StDone: begin
                // Pointers and counters advance even after an error so the controller proceeds.
                if (mode_q) begin
                    dst_ptr_d = dst_ptr_q + BlkBytes;
                    if (wr_cnt_q < nblk_q) begin
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end
                end else begin
                    src_ptr_d = src_ptr_q + BlkBytes;
                    if (rd_cnt_q < nblk_q) begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && ahb_shift_en) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            buf_q      <= '0;
            rx_block_q <= '0;
            word_idx_q <= '0;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            nblk_q     <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            buf_q      <= buf_d;
            rx_block_q <= rx_block_d;
            word_idx_q <= word_idx_d;
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            nblk_q     <= nblk_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign xfer_done  = (state_q == StDone);
    assign rx_valid   = (state_q == StDone) && !mode_q;
    assign rx_block   = rx_block_q;
    assign err        = err_q;
    assign last_round = (wr_cnt_q == nblk_q - CNT_W'(1));

endmodule

// File: tb/tb_aes_ahb_master.sv
// Directed bench for aes_ahb_master: acts as the AHB slave and AES controller,
// checking bus cycles, block data, latency, counters and error handling.
module tb_aes_ahb_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_load;
    logic [31:0]  cfg_src_addr;
    logic [31:0]  cfg_dst_addr;
    logic [15:0]  cfg_num_blocks;
    logic         ahb_mode;
    logic         ahb_shift_en;
    logic [127:0] tx_block;
    logic [127:0] rx_block;
    logic         rx_valid;
    logic         xfer_done;
    logic         last_round;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    aes_ahb_master_if ahb ();

    aes_ahb_master #(
        .NUM_WORDS(4),
        .CNT_W    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_load      (cfg_load),
        .cfg_src_addr  (cfg_src_addr),
        .cfg_dst_addr  (cfg_dst_addr),
        .cfg_num_blocks(cfg_num_blocks),
        .ahb_mode      (ahb_mode),
        .ahb_shift_en  (ahb_shift_en),
        .tx_block      (tx_block),
        .rx_block      (rx_block),
        .rx_valid      (rx_valid),
        .xfer_done     (xfer_done),
        .last_round    (last_round),
        .busy          (busy),
        .err           (err),
        .ahb           (ahb)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Starts and ends at a falling edge.
    task automatic load_cfg(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] nb);
        cfg_src_addr   = src;
        cfg_dst_addr   = dst;
        cfg_num_blocks = nb;
        cfg_load       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // One block transfer with optional stalls on one word and an error response on err_word.
    task automatic do_block(input logic mode, input logic [31:0] base, input logic [127:0] data,
                            input int stall_word, input int a_st, input int d_st,
                            input int err_word, input int exp_cycles);
        int cycles;
        ahb_mode     = mode;
        tx_block     = mode ? data : 128'hDEAD_BEEF;
        ahb_shift_en = 1'b1;
        @(posedge clk);
        cycles = 0;
        @(negedge clk);
        ahb_shift_en = 1'b0;
        for (int w = 0; w < 4; w++) begin
            int a_n;
            int d_n;
            logic [31:0] wd;
            a_n = (w == stall_word) ? a_st : 0;
            d_n = (w == stall_word) ? d_st : 0;
            wd  = data[(3-w)*32 +: 32];
            for (int s = 0; s <= a_n; s++) begin
                check("htrans_addr", ahb.htrans, 2'b10);
                check("haddr", ahb.haddr, base + 32'(4 * w));
                check("hwrite", ahb.hwrite, mode);
                ahb.hready = (s == a_n);
                ahb.hresp  = 1'b0;
                @(posedge clk);
                cycles++;
                @(negedge clk);
            end
            for (int s = 0; s <= d_n; s++) begin
                check("htrans_data", ahb.htrans, 2'b00);
                if (mode) check("hwdata", ahb.hwdata, wd);
                ahb.hready = (s == d_n);
                ahb.hresp  = (w == err_word) && (s == d_n);
                ahb.hrdata = mode ? 32'h0 : wd;
                @(posedge clk);
                cycles++;
                @(negedge clk);
            end
            if (w == err_word) break;
        end
        ahb.hready = 1'b1;
        ahb.hresp  = 1'b0;
        check("xfer_done", xfer_done, 1'b1);
        check("rx_valid", rx_valid, !mode);
        check("latency", cycles + 1, exp_cycles);
        if (!mode && err_word > 3) check("rx_block", rx_block, data);
        @(posedge clk);
        @(negedge clk);
        check("busy_after", busy, 1'b0);
        check("done_after", xfer_done, 1'b0);
    endtask

    initial begin
        int seen;
        rst            = 1'b1;
        cfg_load       = 1'b0;
        cfg_src_addr   = '0;
        cfg_dst_addr   = '0;
        cfg_num_blocks = '0;
        ahb_mode       = 1'b0;
        ahb_shift_en   = 1'b0;
        tx_block       = '0;
        ahb.hrdata     = '0;
        ahb.hready     = 1'b1;
        ahb.hresp      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_htrans", ahb.htrans, 2'b00);
        check("rst_haddr", ahb.haddr, 32'h0);
        check("rst_hwdata", ahb.hwdata, 32'h0);
        check("rst_hwrite", ahb.hwrite, 1'b0);
        check("rst_hsize", ahb.hsize, 3'b010);
        check("rst_rx_block", rx_block, 128'h0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_xfer_done", xfer_done, 1'b0);

        // Single-block job: one read then one write.
        load_cfg(32'h100, 32'h200, 16'd1);
        check("lr_one_block", last_round, 1'b1);
        do_block(1'b0, 32'h100, 128'h11111111_22222222_33333333_44444444, -1, 0, 0, 9, 9);
        check("lr_after_read", last_round, 1'b1);
        do_block(1'b1, 32'h200, 128'hAABBCCDD_44556677_8899EEFF_00112233, -1, 0, 0, 9, 9);
        check("lr_after_write", last_round, 1'b0);

        // Three-block job with read/write alternation, then a saturated extra write.
        load_cfg(32'h1000, 32'h200, 16'd3);
        for (int b = 0; b < 3; b++) begin
            do_block(1'b0, 32'h1000 + 32'(16 * b), 128'h01020304_05060708_090A0B0C_0D0E0F10,
                     -1, 0, 0, 9, 9);
            check("lr_before_write", last_round, (b == 2));
            do_block(1'b1, 32'h200 + 32'(16 * b), 128'hCAFE0000_CAFE0001_CAFE0002_CAFE0003,
                     -1, 0, 0, 9, 9);
        end
        check("lr_saturated", last_round, 1'b0);
        do_block(1'b1, 32'h230, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, -1, 0, 0, 9, 9);
        check("lr_still_sat", last_round, 1'b0);

        // Wait states on word 1: 3 in address phase, 2 in data phase.
        load_cfg(32'h300, 32'h400, 16'd2);
        do_block(1'b0, 32'h300, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 1, 3, 2, 9, 14);

        // Error response on word 2 of a read; pointer still advances, err is sticky.
        do_block(1'b0, 32'h310, 128'h55555555_66666666_77777777_88888888, -1, 0, 0, 2, 7);
        check("err_set", err, 1'b1);
        do_block(1'b0, 32'h320, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, -1, 0, 0, 9, 9);
        check("err_sticky", err, 1'b1);
        load_cfg(32'h0, 32'h0, 16'd0);
        check("err_cleared", err, 1'b0);
        check("lr_zero_blocks", last_round, 1'b1);

        // Request while busy is ignored and flags an error.
        ahb_mode     = 1'b0;
        ahb.hready   = 1'b0;
        ahb.hrdata   = 32'h13572468;
        ahb_shift_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("busy_started", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        ahb_shift_en = 1'b0;
        check("err_busy_req", err, 1'b1);
        ahb.hready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            if (xfer_done) seen = 1;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        check("busy_xfer_seen", seen, 1);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("busy_req_dropped", busy, 1'b0);
        end

        // Reset in the data phase of a write.
        ahb_mode     = 1'b1;
        tx_block     = 128'h76543210_FEDCBA98_00000001_00000002;
        ahb_shift_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ahb_shift_en = 1'b0;
        ahb.hready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_htrans", ahb.htrans, 2'b00);
        check("mid_hwdata", ahb.hwdata, 32'h76543210);
        ahb.hready = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_htrans", ahb.htrans, 2'b00);
        check("mrst_busy", busy, 1'b0);
        check("mrst_haddr", ahb.haddr, 32'h0);
        check("mrst_hwdata", ahb.hwdata, 32'h0);
        check("mrst_hwrite", ahb.hwrite, 1'b0);
        check("mrst_err", err, 1'b0);
        check("mrst_rx_block", rx_block, 128'h0);
        check("mrst_xfer_done", xfer_done, 1'b0);
        check("mrst_last_round", last_round, 1'b0);
        rst        = 1'b0;
        ahb.hready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
